// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, parity selectors, minimum character length.
// No logic; types and constants only.
// Reused by the receiver, so keep it free of TX-only parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with level output; pointers carry an extra wrap bit for full detection.
// Latency: a push is visible on pop_data/level the cycle after the write edge.
// Backpressure: pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop framer with a baud divider.
// Latency: push into an idle empty block -> start bit on the line two edges later.
// Backpressure: wr_ready = !full; frames run back-to-back while the FIFO has words.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DIV_WIDTH-1:0]              baud_div,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]   cfg_data_bits,
  input  logic                              par_en,
  input  logic                              par_type,
  input  logic                              stop2,
  input  logic                              wr_valid,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_ready,
  output logic                              ser_data_out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int BW = $clog2(DATA_WIDTH+1);

  localparam logic [BW-1:0]        MIN_BITS = BW'(MIN_DATA_BITS);
  localparam logic [BW-1:0]        MAX_BITS = BW'(DATA_WIDTH);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(2);

  uart_tx_state_t          state_q, state_d;
  logic                    fifo_full, fifo_empty, pop;
  logic [DATA_WIDTH-1:0]   head;
  logic [DIV_WIDTH-1:0]    div_eff, div_q, tmr_q;
  logic [BW-1:0]           bits_eff, bits_q, bit_cnt_q;
  logic [DATA_WIDTH-1:0]   data_mask, sh_q;
  logic                    par_calc, par_q, par_en_q, stop2_q;
  logic                    bit_end, last_data, last_stop, line_d;

  assign wr_ready = !fifo_full;

  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Clamp the live configuration and pre-compute parity of the head word for latching at pop.
  always_comb begin
    div_eff   = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
    bits_eff  = (cfg_data_bits < MIN_BITS) ? MIN_BITS :
                (cfg_data_bits > MAX_BITS) ? MAX_BITS : cfg_data_bits;
    data_mask = ~({DATA_WIDTH{1'b1}} << bits_eff);
    par_calc  = (^(head & data_mask)) ^ (par_type == PAR_ODD);
  end

  assign bit_end   = (tmr_q == div_q - 1'b1);
  assign last_data = (bit_cnt_q == bits_q - 1'b1);
  assign last_stop = (bit_cnt_q == {{(BW-1){1'b0}}, stop2_q});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, FIFO pop strobe and the line level for the current state.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    line_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: begin
        line_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        line_d = sh_q[0];
        if (bit_end && last_data) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_d = par_q;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end && last_stop) begin
          if (!fifo_empty) begin
            state_d = ST_START;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: config latch at pop, bit timer, bit counter, shifter, registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_data_out <= 1'b1;
      busy         <= 1'b0;
      div_q        <= MIN_DIV;
      tmr_q        <= '0;
      bits_q       <= MIN_BITS;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      par_q        <= 1'b0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
    end else begin
      ser_data_out <= line_d;
      busy         <= (state_q != ST_IDLE) || !fifo_empty;
      if (pop) begin
        div_q     <= div_eff;
        bits_q    <= bits_eff;
        par_en_q  <= par_en;
        stop2_q   <= stop2;
        par_q     <= par_calc;
        sh_q      <= head;
        tmr_q     <= '0;
        bit_cnt_q <= '0;
      end else if (state_q != ST_IDLE) begin
        tmr_q <= bit_end ? '0 : tmr_q + 1'b1;
        if (bit_end) begin
          bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + 1'b1;
          if (state_q == ST_DATA) sh_q <= sh_q >> 1;
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised next-generation UART transmitter with an internal transmit FIFO, on-chip baud divider, runtime-selectable character length, parity and stop-bit count. It sits between the processor's UART register interface and the TX pin. The processor pushes words without waiting for each frame, and the block emits back-to-back frames with no idle gap.

## Interface
- `DATA_WIDTH`, 8: maximum character length in bits; must be at least 5.
- `FIFO_DEPTH`, 4: number of TX FIFO entries; must be a power of 2 and at least 2.
- `DIV_WIDTH`, 16: width of the baud divisor.
- `clk`  in  1  single clock for the block.
- `reset_n`  in  1  asynchronous reset, active low.
- `baud_div`  in  DIV_WIDTH  number of clocks per bit; values 0 and 1 are treated as 2.
- `cfg_data_bits`  in  $clog2(DATA_WIDTH+1)  character length; clamped to the range [5, DATA_WIDTH].
- `par_en`  in  1  1 inserts a parity bit after the data bits.
- `par_type`  in  1  0 selects even parity, 1 selects odd parity.
- `stop2`  in  1  0 sends one stop bit, 1 sends two.
- `wr_valid`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  word to send; only the low `cfg_data_bits` bits are used.
- `wr_ready`  out  1  FIFO can accept a word.
- `ser_data_out`  out  1  TX line; idles high.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- Push happens when `wr_valid && wr_ready`. `wr_ready = !full`, and it depends only on FIFO state: no push is accepted while full, even if a pop occurs in the same cycle. When not full, a simultaneous push and pop leaves `fifo_level` unchanged.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that transition the head word is popped and `baud_div`, `cfg_data_bits`, `par_en`, `par_type` and `stop2` are latched. Configuration changes during a frame have no effect until the next frame.
  - START → DATA after one bit period.
  - DATA sends the bits LSB first. It moves to PARITY (if `par_en`) or STOP after the latched length.
  - PARITY → STOP after one bit period.
  - STOP lasts one or two bit periods. At its end the FSM goes to START if the FIFO is non-empty, with the pop happening on that same edge; otherwise it goes to IDLE.
- Bit timer counts 0..div-1 and wraps. A bit ends when the count reaches div-1. The timer resets to 0 at every frame start.
- Parity is the XOR of the latched data bits, inverted when `par_type=1`. It is computed once, at pop.
- Line levels by state: START 0, DATA the current bit, PARITY the parity bit, STOP and IDLE 1. `ser_data_out` is registered.
- Reset values (asynchronous, at any point including mid-frame):
  - FSM returns to IDLE and the FIFO is emptied.
  - `ser_data_out=1`, `busy=0`, `wr_ready=1`, `fifo_level=0`.
  - Any frame in progress is abandoned with no glitch low.

## Timing
- A push into an empty FIFO while IDLE at edge N: `fifo_level=1` after N, pop at N+1, `ser_data_out` low after N+2.
- Frame length is exactly (1 + bits + par_en + 1 + stop2) × div clocks.
- Back-to-back frames: the next start bit's low level follows the last stop clock directly, with zero extra idle cycles.
- `busy` is registered. It rises the cycle after the first push and falls the cycle after the final stop bit ends with the FIFO empty.
- `wr_ready` rises one cycle after the pop that relieves a full FIFO.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - parity constants `PAR_EVEN`/`PAR_ODD`;
  - the constant `MIN_DATA_BITS=5`.
  Receiver work reuses this package.
- Sub-module `uart_sync_fifo` is a parametrised width/depth FIFO. It provides push/pop, full/empty and level, with pointers one bit wider than the address for full detection.
- Top level contains the FSM, bit timer, bit counter, shift register and parity register.

## Test plan
- Reset: assert `reset_n=0` mid-frame → `ser_data_out=1`, `busy=0`, `fifo_level=0`, `wr_ready=1` immediately, with no further transitions after release.
- Single frame: `baud_div=4`, 8 bits, no parity, 1 stop, push 0xA5 → line is 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 clocks; 40 clocks total; start low 2 clocks after the push.
- Parity and stop bits:
  - 7 bits, odd parity, `stop2=1`, push 0x03 → parity bit 1, two stop bits, 11 bit periods.
  - Same push with even parity → parity bit 0.
- FIFO full: push 6 words back-to-back with `FIFO_DEPTH=4`:
  - first pop frees a slot, so 5 are accepted before `wr_ready` drops;
  - frames are contiguous with zero idle cycles;
  - `busy` falls only after the last stop bit.
- Mid-frame config change: switch `baud_div` 4→8 and `cfg_data_bits` 8→5 during frame 1 → frame 1 is unchanged and frame 2 uses the new values.
- Clamping: `baud_div=0` behaves as 2; `cfg_data_bits=3` behaves as 5.
